// File: rtl/split_slave_ctrl.sv
// Slave-side split sequencer: announces BUSY on the shared split wire, releases it
// once the backing store is done, then waits for the controller's acknowledge.
module split_slave_ctrl #(
    parameter int unsigned MIN_BUSY = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned ACK_TO   = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             split_req,
    input  logic             mem_done,
    input  logic             resp_done,
    inout  wire              split_line,
    output logic             split_active,
    output logic             bus_release,
    output logic             resp_start,
    output logic             ack_timeout,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ANNOUNCE  = 3'd1;
    localparam logic [2:0] S_BUSY      = 3'd2;
    localparam logic [2:0] S_DONE_WAIT = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ACK_TO_M1 = CNT_W'(ACK_TO - 1);
    localparam logic [CNT_W:0]   MIN_C     = (CNT_W+1)'(MIN_BUSY);

    logic [2:0]       state_nxt;
    logic             drive;
    logic             line_in;
    logic             start;
    logic             hold_met;
    logic [CNT_W:0]   drive_cnt;
    logic             mem_seen, mem_seen_d;
    logic             seen_low, seen_low_d;
    logic             wd_fired, wd_fired_d;
    logic             wd_fire;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_d;
    logic [CNT_W-1:0] busy_d;
    logic             split_active_d, bus_release_d, resp_start_d;

    assign drive      = (state == S_ANNOUNCE) || (state == S_BUSY);
    assign split_line = drive ? 1'b1 : 1'bz;
    assign line_in    = split_line;

    // Driven-cycle count including the current cycle, one bit wider so it never wraps.
    assign drive_cnt = {1'b0, busy_cycles} + (CNT_W+1)'(1);
    assign hold_met  = (drive_cnt >= MIN_C);
    assign start     = (state == S_IDLE) && split_req;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            split_active <= 1'b0;
            bus_release  <= 1'b0;
            resp_start   <= 1'b0;
            ack_timeout  <= 1'b0;
            busy_cycles  <= '0;
            mem_seen     <= 1'b0;
            seen_low     <= 1'b0;
            wd_fired     <= 1'b0;
            wd_cnt       <= '0;
        end else begin
            state        <= state_nxt;
            split_active <= split_active_d;
            bus_release  <= bus_release_d;
            resp_start   <= resp_start_d;
            ack_timeout  <= wd_fire;
            busy_cycles  <= busy_d;
            mem_seen     <= mem_seen_d;
            seen_low     <= seen_low_d;
            wd_fired     <= wd_fired_d;
            wd_cnt       <= wd_cnt_d;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:      state_nxt = split_req ? S_ANNOUNCE : S_IDLE;
            S_ANNOUNCE:  state_nxt = S_BUSY;
            S_BUSY:      state_nxt = ((mem_seen || mem_done) && hold_met) ? S_DONE_WAIT : S_BUSY;
            S_DONE_WAIT: state_nxt = (seen_low && line_in) ? S_RESPOND : S_DONE_WAIT;
            S_RESPOND:   state_nxt = resp_done ? S_IDLE : S_RESPOND;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        split_active_d = (state_nxt != S_IDLE);
        bus_release_d  = (state_nxt == S_ANNOUNCE);
        resp_start_d   = (state_nxt == S_RESPOND) && (state != S_RESPOND);

        busy_d = busy_cycles;
        if (start)
            busy_d = '0;
        else if (drive && (busy_cycles != CNT_MAX))
            busy_d = busy_cycles + CNT_ONE;

        mem_seen_d = mem_seen;
        if (start)
            mem_seen_d = 1'b0;
        else if (drive)
            mem_seen_d = mem_seen | mem_done;

        // A high seen before any low could be our own line still decaying; require a low first.
        seen_low_d = (state == S_DONE_WAIT) ? (seen_low | ~line_in) : 1'b0;

        wd_cnt_d = wd_cnt;
        if (start)
            wd_cnt_d = '0;
        else if ((state == S_DONE_WAIT) && (wd_cnt != CNT_MAX))
            wd_cnt_d = wd_cnt + CNT_ONE;

        wd_fire    = (state == S_DONE_WAIT) && !wd_fired && (wd_cnt == ACK_TO_M1);
        wd_fired_d = start ? 1'b0 : (wd_fired | wd_fire);
    end

endmodule

// File: tb/tb_split_slave_ctrl.sv
// Randomized split sequences against a transaction-level model; a monitor checks
// every bus_release / ack_timeout / resp_start pulse against a scoreboard queue.
module tb_split_slave_ctrl;

    localparam int MIN_BUSY = 3;
    localparam int CNT_W    = 3;
    localparam int ACK_TO   = 5;
    localparam int BMAX     = (1 << CNT_W) - 1;

    localparam int K_BR = 0;
    localparam int K_TO = 1;
    localparam int K_RS = 2;

    typedef struct {
        int kind;
        int cyc;
        int busy;
        int len;
    } ev_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             split_req = 1'b0;
    logic             mem_done = 1'b0;
    logic             resp_done = 1'b0;
    logic             ctrl_drv = 1'b0;
    wire              split_line;
    logic             split_active, bus_release, resp_start, ack_timeout;
    logic [CNT_W-1:0] busy_cycles;
    logic [2:0]       state;

    ev_t exp_q[$];
    int  cyc = 0;
    int  drv_cnt = 0;
    int  nchk = 0;
    int  nerr = 0;

    assign split_line = ctrl_drv ? 1'b1 : 1'bz;
    pulldown (split_line);

    split_slave_ctrl #(.MIN_BUSY(MIN_BUSY), .CNT_W(CNT_W), .ACK_TO(ACK_TO)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .split_req    (split_req),
        .mem_done     (mem_done),
        .resp_done    (resp_done),
        .split_line   (split_line),
        .split_active (split_active),
        .bus_release  (bus_release),
        .resp_start   (resp_start),
        .ack_timeout  (ack_timeout),
        .busy_cycles  (busy_cycles),
        .state        (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == K_BR) begin
                chk("announce_state", int'(state), 1);
                chk("busy_cleared", int'(busy_cycles), 0);
            end
            if (kind == K_RS) begin
                chk("respond_state", int'(state), 4);
                chk("respond_active", int'(split_active), 1);
                chk("busy_cycles", int'(busy_cycles), e.busy);
                chk("line_high_len", drv_cnt, e.len);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (bus_release) drv_cnt = 0;
            if (split_line === 1'b1 && !ctrl_drv) drv_cnt++;
            if (bus_release) check_ev(K_BR);
            if (ack_timeout) check_ev(K_TO);
            if (resp_start)  check_ev(K_RS);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // j_mem: driven cycle (1 = ANNOUNCE) carrying the mem_done pulse.
    // a_ack: DONE_WAIT cycle (0 = first) in which the controller drives the line high.
    task automatic do_split(input int j_mem, input int guard, input int a_ack,
                            input int r_done, input int force_req);
        int s, len, dw, t_end;
        s     = cyc;
        len   = (j_mem > MIN_BUSY) ? j_mem : MIN_BUSY;
        dw    = s + 1 + len;
        t_end = dw + a_ack + 1 + r_done;
        exp_q.push_back('{K_BR, s + 1, 0, 0});
        if (a_ack >= ACK_TO - 1)
            exp_q.push_back('{K_TO, dw + ACK_TO, 0, 0});
        exp_q.push_back('{K_RS, dw + a_ack + 1, (len > BMAX) ? BMAX : len, len});

        split_req = 1'b1;
        mem_done  = 1'b0;
        resp_done = 1'b0;
        ctrl_drv  = 1'b0;
        for (int t = s + 1; t <= t_end; t++) begin
            step();
            mem_done  = (t == s + j_mem) || (t >= dw && $urandom_range(0, 3) == 0);
            ctrl_drv  = (guard != 0 && t == dw) || (t == dw + a_ack);
            resp_done = (t == t_end);
            split_req = ($urandom_range(0, 3) == 0) || (force_req != 0 && t > dw + a_ack);
        end
        step();
        split_req = 1'b0;
        mem_done  = 1'b0;
        resp_done = 1'b0;
        ctrl_drv  = 1'b0;
        chk("idle_state", int'(state), 0);
        chk("idle_active", int'(split_active), 0);
        chk("idle_line", int'(split_line), 0);
    endtask

    initial begin
        int s, j, g, a;
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_active", int'(split_active), 0);
        chk("rst_release", int'(bus_release), 0);
        chk("rst_resp_start", int'(resp_start), 0);
        chk("rst_timeout", int'(ack_timeout), 0);
        chk("rst_busy", int'(busy_cycles), 0);
        chk("rst_line", int'(split_line), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step();

        do_split(6, 0, 2, 2, 0);   // basic: release after cycle 6, ack cycle 9, resp_done 12
        step();
        do_split(1, 0, 1, 0, 1);   // mem_done during ANNOUNCE; split_req held in RESPOND
        do_split(2, 1, 2, 1, 0);   // residual-high guard
        do_split(4, 0, 8, 1, 0);   // watchdog fires, late ack honoured
        do_split(3, 0, 4, 0, 0);   // ack on the watchdog's last cycle
        do_split(12, 0, 1, 0, 0);  // busy_cycles saturates

        for (int n = 0; n < 40; n++) begin
            j = $urandom_range(1, 12);
            g = $urandom_range(0, 1);
            a = $urandom_range((g != 0) ? 2 : 1, 9);
            do_split(j, g, a, $urandom_range(0, 3), $urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step();
        end

        // Reset in the middle of BUSY: the line must drop at once and no response follows.
        s = cyc;
        exp_q.push_back('{K_BR, s + 1, 0, 0});
        split_req = 1'b1;
        step();
        split_req = 1'b0;
        step();
        step();
        step();
        chk("busy_line_driven", int'(split_line), 1);
        rstn = 1'b0;
        #1;
        chk("midrst_line", int'(split_line), 0);
        chk("midrst_state", int'(state), 0);
        chk("midrst_active", int'(split_active), 0);
        chk("midrst_busy", int'(busy_cycles), 0);
        chk("midrst_resp_start", int'(resp_start), 0);
        mem_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        mem_done = 1'b0;
        repeat (8) step();
        chk("post_rst_state", int'(state), 0);
        do_split(5, 1, 3, 1, 0);
        repeat (4) step();

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/split_slave_ctrl.md
# split_slave_ctrl

Slave-side split-transaction sequencer for the shared-bus fabric. It drives one slave's single-wire split line toward the bus controller. On a slow access it announces BUSY so the controller can block the master and free the bus, and it releases the line when the backing store completes. It then waits for the controller's one-cycle acknowledge pulse and starts the slave's response phase. One instance sits between each splittable slave's bus interface and its split wire.

## Interface
- MIN_BUSY, 2: minimum number of cycles split_line is driven high; legal range ≥2.
- CNT_W, 8: width of busy_cycles and of the acknowledge watchdog counter.
- ACK_TO, 255: number of DONE_WAIT cycles before ack_timeout fires; range 1..2^CNT_W-1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rstn  in  1  reset, asynchronous, active-low.
- split_req  in  1  the current addressed transaction needs a split. Sampled only in IDLE.
- mem_done  in  1  backing store has the response ready; level or pulse.
- resp_done  in  1  the slave bus interface has finished returning data.
- split_line  inout  1  shared split wire. Driven 1 or released to Z; the board pull-down gives 0 when undriven.
- split_active  out  1  high in every state except IDLE.
- bus_release  out  1  one-cycle pulse in ANNOUNCE; tells the bus interface to end the current handshake.
- resp_start  out  1  one-cycle pulse on the first RESPOND cycle.
- ack_timeout  out  1  one-cycle pulse when the watchdog expires.
- busy_cycles  out  CNT_W  cycles split_line was driven in the last or current split; saturating.
- state  out  3  current state code, for debug.

## Operation
- States and encoding: IDLE=0, ANNOUNCE=1, BUSY=2, DONE_WAIT=3, RESPOND=4. Codes 5–7 go to IDLE on the next edge.
- split_line drive:
  - Driven 1 in ANNOUNCE and BUSY.
  - Z in all other states, and during reset.
  - The block never drives 0.
- IDLE → ANNOUNCE when split_req=1.
  - On this transition: clear busy_cycles to 0, clear the mem_done latch, clear the watchdog.
- ANNOUNCE (always exactly 1 cycle) → BUSY.
  - bus_release=1 during this cycle.
- BUSY → DONE_WAIT when both hold:
  - the mem_done latch is set OR mem_done=1 this cycle;
  - driven-cycle count (ANNOUNCE + BUSY cycles, including the current one) ≥ MIN_BUSY.
  - mem_done arriving earlier (including during ANNOUNCE) is latched (sticky) and acted on once the hold is met.
- DONE_WAIT:
  - The line is released.
  - Flag seen_low sets on the first edge that samples split_line=0.
  - Acknowledge = split_line sampled 1 while seen_low=1 → RESPOND.
  - A 1 sampled before seen_low is ignored (guards against residual self-drive).
- RESPOND:
  - resp_start pulses on entry.
  - Stay until resp_done=1, then → IDLE.
- busy_cycles:
  - +1 per ANNOUNCE/BUSY cycle; saturates at 2^CNT_W-1.
  - Holds its value after the split until the next ANNOUNCE.
- Watchdog:
  - Counts DONE_WAIT cycles.
  - When the count reaches ACK_TO, ack_timeout pulses once; a sticky flag suppresses repeats.
  - State remains DONE_WAIT; an acknowledge arriving later is still honoured.
- Simultaneous events:
  - split_req outside IDLE is ignored, not queued.
  - resp_done and split_req in the same RESPOND cycle → IDLE only.
  - mem_done outside ANNOUNCE/BUSY is ignored.
- Reset mid-operation: line released immediately (asynchronously), all state cleared; the bus controller recovers via its own reset.

## Timing
- Reset values:
  - state=0, split_active=0, bus_release=0, resp_start=0, ack_timeout=0, busy_cycles=0.
  - split_line=Z.
- split_req sampled at edge E0 (cycle 0): line=1 and bus_release=1 in cycle 1.
- Minimum line-high duration is MIN_BUSY cycles; with mem_done already present it is exactly MIN_BUSY.
- Release: mem_done sampled in cycle k with the hold satisfied → line Z from cycle k+1.
- Acknowledge: split_line=1 sampled in cycle m (seen_low=1) → resp_start=1 in cycle m+1.
- Minimum DONE_WAIT duration before an acknowledge can be accepted: 2 cycles (one low sample, then the high).
- All outputs are registered except split_line, which is a combinational tristate of state.

## Test plan
- Basic split, MIN_BUSY=2:
  - Stimulus: split_req in cycle 0, mem_done in cycle 6, controller pulses the line in cycle 9, resp_done in cycle 12.
  - Required: line high cycles 1–6, Z from 7; busy_cycles=6; resp_start in cycle 10; IDLE in cycle 13.
- Early mem_done:
  - Stimulus: mem_done high during ANNOUNCE, MIN_BUSY=4.
  - Required: line high exactly cycles 1–4; busy_cycles=4.
- Ack guard:
  - Stimulus: force split_line=1 on the first DONE_WAIT cycle, then 0, then 1.
  - Required: first high ignored; RESPOND only after the second high.
- Watchdog, ACK_TO=5:
  - Stimulus: no acknowledge.
  - Required: ack_timeout single pulse after 5 DONE_WAIT cycles; a later acknowledge still gives resp_start.
- Reset and ignore cases:
  - Stimulus: rstn low mid-BUSY; separately, split_req during RESPOND.
  - Required: reset → line Z and state=0 immediately, with no resp_start. split_req in RESPOND → no new ANNOUNCE.
- Saturation, CNT_W=3:
  - Stimulus: mem_done 12 cycles after ANNOUNCE.
  - Required: busy_cycles=7.
